// File: rtl/servo_pwm_gen_if.sv
// servo_pwm_gen_if
//   Angle-word handshake between an angle source and servo_pwm_gen.
//   angle_in    : requested angle in degrees (source -> generator)
//   angle_valid : angle_in holds a word to transfer (source -> generator)
//   angle_ready : generator can take a word; transfer on valid & ready
interface servo_pwm_gen_if;
   logic [7:0] angle_in;
   logic       angle_valid;
   logic       angle_ready;

   modport master (output angle_in, output angle_valid, input angle_ready);
   modport slave  (input angle_in, input angle_valid, output angle_ready);
endinterface

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen
//   Drives one hobby-servo PWM line from a 0..180 degree angle stream.
//   Incoming angles land in a one-deep shadow register. The shadow is copied
//   into the active angle only at a frame boundary, so a pulse is never cut
//   short or stretched by a mid-frame update.
// Ports
//   clk          : system clock
//   reset_n      : synchronous, active-low reset
//   enable       : 1 = generate frames, 0 = stop after the current frame
//   angle        : angle handshake (slave side)
//   pwm_out      : servo pulse, high for pulse_us microseconds per frame
//   frame_start  : one-cycle strobe on the first cycle of each frame
//   active_angle : angle in use for the current frame
//   pulse_us     : pulse width of the current frame in microseconds
//   range_err    : one-cycle strobe, accepted angle was > 180 (clamped)
module servo_pwm_gen #(
   parameter int unsigned TICKS_PER_US = 12,
   parameter int unsigned FRAME_US     = 20000,
   parameter int unsigned MIN_US       = 500,
   parameter int unsigned SCALE_Q16    = 728178,
   parameter int unsigned RESET_ANGLE  = 90
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   servo_pwm_gen_if.slave   angle,
   output logic             pwm_out,
   output logic             frame_start,
   output logic [7:0]       active_angle,
   output logic [11:0]      pulse_us,
   output logic             range_err
);

   localparam int unsigned   PW        = $clog2(TICKS_PER_US);
   localparam int unsigned   FW        = $clog2(FRAME_US);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_US - 1);
   localparam logic [FW-1:0] FRAME_MAX = FW'(FRAME_US - 1);

   // MIN_US + floor(a * SCALE_Q16 / 65536), 28-bit product, no rounding.
   function automatic logic [11:0] pulse_of(input logic [7:0] a);
      logic [27:0] prod;
      prod = 28'(a) * 28'(SCALE_Q16);
      return 12'(MIN_US) + 12'(prod >> 16);
   endfunction

   localparam logic [7:0]  RESET_ANG   = 8'(RESET_ANGLE);
   localparam logic [11:0] RESET_PULSE = pulse_of(RESET_ANG);

   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

   state_t         state, state_n;
   logic [PW-1:0]  presc, presc_n;
   logic [FW-1:0]  frame_cnt, frame_n;
   logic [7:0]     shadow;
   logic           shadow_full;
   logic           apply, apply_upd;
   logic           accept;
   logic [7:0]     angle_n;
   logic [11:0]    pulse_n;
   logic           pwm_n, frame_start_n;

   assign angle.angle_ready = !shadow_full;
   assign accept            = angle.angle_valid && !shadow_full;

   always_comb begin
      state_n = state;
      presc_n = presc;
      frame_n = frame_cnt;
      apply   = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable) begin
               state_n = RUN;
               apply   = 1'b1;
            end
         end
         RUN, STOPPING: begin
            if (presc == PRESC_MAX && frame_cnt == FRAME_MAX) begin
               // Frame boundary: either roll into a new frame or park in IDLE.
               presc_n = '0;
               frame_n = '0;
               if (enable) begin
                  state_n = RUN;
                  apply   = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               state_n = enable ? RUN : STOPPING;
               if (presc == PRESC_MAX) begin
                  presc_n = '0;
                  frame_n = frame_cnt + 1'b1;
               end else begin
                  presc_n = presc + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      apply_upd = apply && shadow_full;
      angle_n   = apply_upd ? shadow : active_angle;
      pulse_n   = apply_upd ? pulse_of(shadow) : pulse_us;

      // Outputs are registered from next-state values so the pin is a clean
      // flop output; the pulse is high while the elapsed microsecond count is
      // below pulse_us, i.e. exactly pulse_us*TICKS_PER_US cycles.
      pwm_n         = (state_n != IDLE) && (32'(frame_n) < 32'(pulse_n));
      frame_start_n = (state_n != IDLE) && (presc_n == '0) && (frame_n == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         presc        <= '0;
         frame_cnt    <= '0;
         shadow       <= '0;
         shadow_full  <= 1'b0;
         active_angle <= RESET_ANG;
         pulse_us     <= RESET_PULSE;
         pwm_out      <= 1'b0;
         frame_start  <= 1'b0;
         range_err    <= 1'b0;
      end else begin
         state        <= state_n;
         presc        <= presc_n;
         frame_cnt    <= frame_n;
         active_angle <= angle_n;
         pulse_us     <= pulse_n;
         pwm_out      <= pwm_n;
         frame_start  <= frame_start_n;
         range_err    <= accept && (angle.angle_in > 8'd180);
         // accept and apply_upd are mutually exclusive: a full shadow blocks accept.
         if (accept) begin
            shadow      <= (angle.angle_in > 8'd180) ? 8'd180 : angle.angle_in;
            shadow_full <= 1'b1;
         end else if (apply_upd) begin
            shadow_full <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen
//   Scoreboard bench for servo_pwm_gen with a shortened timebase:
//   4 ticks/us, 600 us frames (2400 cycles), 50..250 us pulse range.
//   Hand-computed pulse widths: 0->50, 45->100, 90->150, 135->200, 180->250.
module tb_servo_pwm_gen;
   localparam int unsigned TICKS = 4;
   localparam int unsigned FRAME = 600;
   localparam int unsigned FC    = TICKS * FRAME;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic        pwm_out, frame_start, range_err;
   logic [7:0]  active_angle;
   logic [11:0] pulse_us;

   servo_pwm_gen_if aif();

   servo_pwm_gen #(
      .TICKS_PER_US(4),
      .FRAME_US    (600),
      .MIN_US      (50),
      .SCALE_Q16   (72818),
      .RESET_ANGLE (90)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .angle       (aif),
      .pwm_out     (pwm_out),
      .frame_start (frame_start),
      .active_angle(active_angle),
      .pulse_us    (pulse_us),
      .range_err   (range_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  ang;
      logic [11:0] pus;
      int unsigned hi;
      int unsigned len;
      bit          glitch;
   } frame_t;

   frame_t      exp_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned stray = 0;

   task automatic chk(input string name, input int unsigned act, input int unsigned req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [7:0] a, input logic [11:0] p);
      frame_t f;
      f.ang = a; f.pus = p; f.hi = p * TICKS; f.len = FC; f.glitch = 1'b0;
      exp_q.push_back(f);
   endtask

   // ---------------- monitor / scoreboard ----------------
   frame_t cur;
   bit     in_frame = 1'b0;
   bit     fell = 1'b0;

   task automatic emit(input frame_t got);
      frame_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL frame_unexpected: got angle=%0d pulse_us=%0d high=%0d len=%0d, required no frame",
                  got.ang, got.pus, got.hi, got.len);
      end else begin
         e = exp_q.pop_front();
         if (got.ang !== e.ang || got.pus !== e.pus || got.hi != e.hi ||
             got.len != e.len || got.glitch != e.glitch) begin
            n_err++;
            $display("FAIL frame: got angle=%0d pulse_us=%0d high=%0d len=%0d glitch=%0d, required angle=%0d pulse_us=%0d high=%0d len=%0d glitch=0",
                     got.ang, got.pus, got.hi, got.len, got.glitch, e.ang, e.pus, e.hi, e.len);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         in_frame = 1'b0;
      end else begin
         if (frame_start) begin
            if (in_frame) emit(cur);
            in_frame   = 1'b1;
            fell       = 1'b0;
            cur.ang    = active_angle;
            cur.pus    = pulse_us;
            cur.hi     = 0;
            cur.len    = 0;
            cur.glitch = 1'b0;
         end
         if (in_frame) begin
            if (pwm_out) begin
               if (fell) cur.glitch = 1'b1;
               cur.hi++;
            end else begin
               fell = 1'b1;
            end
            if (active_angle !== cur.ang || pulse_us !== cur.pus) cur.glitch = 1'b1;
            cur.len++;
            if (cur.len == FC) begin
               emit(cur);
               in_frame = 1'b0;
            end
         end else if (pwm_out) begin
            stray++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_fs(input int unsigned budget, output int unsigned n, output bit seen);
      seen = 1'b0;
      n    = 0;
      while (!seen && n < budget) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (frame_start) seen = 1'b1;
      end
   endtask

   task automatic send(input logic [7:0] a, output int unsigned waited);
      waited = 0;
      @(posedge clk);
      #1;
      aif.angle_in    = a;
      aif.angle_valid = 1'b1;
      @(negedge clk);
      while (!aif.angle_ready && waited < 5000) begin
         waited++;
         @(negedge clk);
      end
      if (!aif.angle_ready) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      aif.angle_valid = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pwm_out"},      pwm_out, 0);
      chk({tag, "_frame_start"},  frame_start, 0);
      chk({tag, "_range_err"},    range_err, 0);
      chk({tag, "_angle_ready"},  aif.angle_ready, 1);
      chk({tag, "_active_angle"}, active_angle, 90);
      chk({tag, "_pulse_us"},     pulse_us, 150);
   endtask

   initial begin
      int unsigned n, w;
      bit          seen;
      aif.angle_in    = '0;
      aif.angle_valid = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");
      cyc(1);
      reset_n = 1'b1;
      cyc(5);
      chk("idle_no_frame_start", frame_start, 0);

      // Frame A: reset angle 90
      push_exp(8'd90, 12'd150);
      enable = 1'b1;
      wait_fs(10, n, seen);
      chk("start_seen", seen, 1);
      chk("start_latency", n, 1);

      // Mid-pulse write 0 -> frame B uses 0
      cyc(100);
      push_exp(8'd0, 12'd50);
      send(8'd0, w);
      @(negedge clk);
      chk("write0_range_err", range_err, 0);
      chk("write0_ready_low", aif.angle_ready, 0);
      wait_fs(FC + 10, n, seen);
      chk("frameB_seen", seen, 1);

      // Out-of-range write 200 -> clamped to 180 in frame C
      cyc(50);
      push_exp(8'd180, 12'd250);
      send(8'd200, w);
      @(negedge clk);
      chk("write200_range_err_hi", range_err, 1);
      @(negedge clk);
      chk("write200_range_err_lo", range_err, 0);
      wait_fs(FC + 10, n, seen);
      chk("frameC_seen", seen, 1);

      // 45 then 135 in one frame: 135 held until the boundary
      cyc(10);
      push_exp(8'd45, 12'd100);
      push_exp(8'd135, 12'd200);
      send(8'd45, w);
      @(negedge clk);
      chk("ready_low_after_45", aif.angle_ready, 0);
      send(8'd135, w);
      chk("135_wait_cycles", w, 2387);

      // Brief enable drop inside frame D: no gap, no change
      cyc(50);
      enable = 1'b0;
      cyc(20);
      enable = 1'b1;
      wait_fs(FC + 10, n, seen);
      chk("frameE_seen", seen, 1);

      // Stop during the pulse of frame E
      cyc(100);
      enable = 1'b0;
      wait_fs(3000, n, seen);
      chk("no_restart_after_stop", seen, 0);
      chk("pwm_low_when_stopped", pwm_out, 0);

      // Re-enable: frame F on the next cycle, keeps 135
      cyc(1);
      push_exp(8'd135, 12'd200);
      enable = 1'b1;
      wait_fs(10, n, seen);
      chk("restart_seen", seen, 1);
      chk("restart_latency", n, 1);

      // Reset in the middle of the pulse of frame F, with a word pending
      send(8'd0, w);
      cyc(300);
      @(negedge clk);
      chk("pwm_high_before_reset", pwm_out, 1);
      void'(exp_q.pop_back());
      cyc(1);
      reset_n = 1'b0;
      enable  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_reset_vals("midpulse_reset");

      // After reset: frame G at the reset angle, then stop
      cyc(2);
      reset_n = 1'b1;
      enable  = 1'b1;
      push_exp(8'd90, 12'd150);
      wait_fs(10, n, seen);
      chk("post_reset_start_latency", n, 1);
      cyc(10);
      enable = 1'b0;
      wait_fs(3000, n, seen);
      chk("no_restart_final", seen, 0);

      chk("scoreboard_drained", exp_q.size(), 0);
      chk("stray_pwm_cycles", stray, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
